// File: rtl/regwb_pkg.sv
// Shared types for the register-file writeback scheduler.
// Holds the buffered long-latency result entry layout.
package regwb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries.
// Pushes while full and pops while empty are ignored.
module wb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              din,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regwb_scheduler.sv
// Arbitrates the register-file write port between pipeline
// writeback and buffered long-latency results; drives decode stall.
module regwb_scheduler
  import regwb_pkg::*;
#(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_issue,
  input  logic [4:0]  lu_dest,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_we,
  input  logic [4:0]  id_dest,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int OW = $clog2(LU_DEPTH) + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_entry_t     head;
  wb_entry_t     din;
  logic          empty;
  logic [OW-1:0] occ;
  logic          push;
  logic          pop;
  logic [31:0]   pending;
  logic [31:0]   pend_next;
  logic [CW-1:0] wait_cnt;
  logic          starve;

  assign din      = wb_entry_t'{addr: lu_waddr, data: lu_wdata};
  assign lu_ready = (occ != OW'(LU_DEPTH));
  assign push     = lu_valid & lu_ready;
  assign pop      = ~pipe_we & ~empty;

  wb_fifo #(
    .DEPTH (LU_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .count (occ)
  );

  // Pipeline always wins; $0 targets are granted but never written.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (pipe_we) begin
      rf_we    = reset & (pipe_waddr != '0);
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else if (!empty) begin
      rf_we    = reset & (head.addr != '0);
      rf_waddr = head.addr;
      rf_wdata = head.data;
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the bit.
  always_comb begin
    pend_next = pending;
    if (pop) pend_next[head.addr] = 1'b0;
    if (lu_issue && (lu_dest != '0)) pend_next[lu_dest] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pend_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (pop) begin
      wait_cnt <= '0;
    end else if (!empty && (wait_cnt != CW'(STARVE_MAX))) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign starve = (wait_cnt >= CW'(STARVE_MAX));

  assign stall = pending[id_rs]
               | pending[id_rt]
               | (id_we & pending[id_dest])
               | (lu_issue & pending[lu_dest])
               | starve;

endmodule

// File: tb/tb_regwb_scheduler.sv
// Bench for regwb_scheduler: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_regwb_scheduler;

  localparam int LU_DEPTH   = 2;
  localparam int STARVE_MAX = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_issue;
  logic [4:0]  lu_dest;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_we;
  logic [4:0]  id_dest;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clock = ~clock;

  regwb_scheduler #(
    .LU_DEPTH   (LU_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .lu_issue   (lu_issue),
    .lu_dest    (lu_dest),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_we      (id_we),
    .id_dest    (id_dest),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   mpend[32];
  int   mwait;

  logic        e_ready;
  logic        e_stall;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  int ncmp  = 0;
  int nfail = 0;

  task automatic model_clear();
    mq.delete();
    foreach (mpend[i]) mpend[i] = 1'b0;
    mwait = 0;
  endtask

  task automatic model_eval();
    e_ready = (mq.size() < LU_DEPTH);
    e_we    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    if (pipe_we) begin
      e_we   = (pipe_waddr != 0);
      e_addr = pipe_waddr;
      e_data = pipe_wdata;
    end else if (mq.size() > 0) begin
      e_we   = (mq[0].a != 0);
      e_addr = mq[0].a;
      e_data = mq[0].d;
    end
    if (!reset) e_we = 1'b0;
    e_stall = mpend[id_rs] || mpend[id_rt]
           || (id_we && mpend[id_dest])
           || (lu_issue && mpend[lu_dest])
           || (mwait >= STARVE_MAX);
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    bit   popped;
    bit   took;
    ent_t e;
    model_eval();
    if (!reset) begin
      model_clear();
    end else begin
      popped = !pipe_we && (mq.size() > 0);
      took   = lu_valid && e_ready;
      if (popped) begin
        mpend[mq[0].a] = 1'b0;
        void'(mq.pop_front());
        mwait = 0;
      end else if (mq.size() > 0) begin
        mwait++;
      end
      if (took) begin
        e.a = lu_waddr;
        e.d = lu_wdata;
        mq.push_back(e);
      end
      if (lu_issue && lu_dest != 0) mpend[lu_dest] = 1'b1;
    end
    @(posedge clock);
    #2;
  endtask

  task automatic clear_in();
    pipe_we    = 1'b0;
    pipe_waddr = '0;
    pipe_wdata = '0;
    lu_issue   = 1'b0;
    lu_dest    = '0;
    lu_valid   = 1'b0;
    lu_waddr   = '0;
    lu_wdata   = '0;
    id_rs      = '0;
    id_rt      = '0;
    id_we      = 1'b0;
    id_dest    = '0;
  endtask

  task automatic test_reset();
    clear_in();
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h1;
    reset = 1'b0;
    #3;
    ncmp++; if (lu_ready !== 1'b1) begin
      nfail++; $display("FAIL rst_ready got %b want 1", lu_ready); end
    ncmp++; if (stall !== 1'b0) begin
      nfail++; $display("FAIL rst_stall got %b want 0", stall); end
    ncmp++; if (rf_we !== 1'b0) begin
      nfail++; $display("FAIL rst_rf_we got %b want 0", rf_we); end
    step();
    reset = 1'b1;
    clear_in();
    #1;
    ncmp++; if (rf_we !== 1'b0) begin
      nfail++; $display("FAIL rst_idle_we got %b want 0", rf_we); end
    step();
  endtask

  task automatic test_raw();
    clear_in();
    lu_issue = 1'b1; lu_dest = 5'd5;
    step();
    clear_in();
    id_rs = 5'd5;
    #1;
    ncmp++; if (stall !== 1'b1) begin
      nfail++; $display("FAIL raw_stall got %b want 1", stall); end
    lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
    #1;
    ncmp++; if (lu_ready !== 1'b1) begin
      nfail++; $display("FAIL raw_ready got %b want 1", lu_ready); end
    ncmp++; if (rf_we !== 1'b0) begin
      nfail++; $display("FAIL raw_idle_we got %b want 0", rf_we); end
    step();
    clear_in();
    id_rs = 5'd5;
    #1;
    ncmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
      nfail++; $display("FAIL raw_commit got we=%b a=%0d want we=1 a=5",
                        rf_we, rf_waddr); end
    ncmp++; if (rf_wdata !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL raw_data got %h want deadbeef", rf_wdata); end
    ncmp++; if (stall !== 1'b1) begin
      nfail++; $display("FAIL raw_hold got %b want 1", stall); end
    step();
    #1;
    ncmp++; if (stall !== 1'b0) begin
      nfail++; $display("FAIL raw_release got %b want 0", stall); end
    step();
  endtask

  task automatic test_starve();
    clear_in();
    pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = $urandom;
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h11;
    step();
    lu_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      ncmp++; if (stall !== (i >= STARVE_MAX)) begin
        nfail++; $display("FAIL starve_stall cyc=%0d got %b want %b",
                          i, stall, (i >= STARVE_MAX)); end
      ncmp++; if (rf_waddr !== 5'd10 || rf_we !== 1'b1) begin
        nfail++; $display("FAIL starve_pipe got we=%b a=%0d want we=1 a=10",
                          rf_we, rf_waddr); end
      step();
    end
    pipe_we = 1'b0;
    #1;
    ncmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      nfail++; $display("FAIL starve_commit got we=%b a=%0d want we=1 a=7",
                        rf_we, rf_waddr); end
    ncmp++; if (rf_wdata !== 32'h11 || stall !== 1'b1) begin
      nfail++; $display("FAIL starve_head got d=%h st=%b want d=11 st=1",
                        rf_wdata, stall); end
    step();
    #1;
    ncmp++; if (stall !== 1'b0) begin
      nfail++; $display("FAIL starve_clear got %b want 0", stall); end
    step();
  endtask

  task automatic test_full();
    clear_in();
    pipe_we = 1'b1; pipe_waddr = 5'd20;
    lu_valid = 1'b1; lu_waddr = 5'd12; lu_wdata = 32'hAA;
    step();
    lu_waddr = 5'd13; lu_wdata = 32'hBB;
    step();
    lu_waddr = 5'd14; lu_wdata = 32'hCC;
    #1;
    ncmp++; if (lu_ready !== 1'b0) begin
      nfail++; $display("FAIL full_ready got %b want 0", lu_ready); end
    step();
    #1;
    ncmp++; if (lu_ready !== 1'b0) begin
      nfail++; $display("FAIL full_hold got %b want 0", lu_ready); end
    pipe_we = 1'b0;
    #1;
    ncmp++; if (rf_waddr !== 5'd12 || rf_wdata !== 32'hAA) begin
      nfail++; $display("FAIL full_first got a=%0d d=%h want a=12 d=aa",
                        rf_waddr, rf_wdata); end
    step();
    #1;
    ncmp++; if (lu_ready !== 1'b1) begin
      nfail++; $display("FAIL full_reopen got %b want 1", lu_ready); end
    ncmp++; if (rf_waddr !== 5'd13 || rf_wdata !== 32'hBB) begin
      nfail++; $display("FAIL full_second got a=%0d d=%h want a=13 d=bb",
                        rf_waddr, rf_wdata); end
    step();
    lu_valid = 1'b0;
    #1;
    ncmp++; if (rf_waddr !== 5'd14 || rf_wdata !== 32'hCC) begin
      nfail++; $display("FAIL full_third got a=%0d d=%h want a=14 d=cc",
                        rf_waddr, rf_wdata); end
    step();
    #1;
    ncmp++; if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
      nfail++; $display("FAIL full_drained got rdy=%b we=%b want 1 0",
                        lu_ready, rf_we); end
    step();
  endtask

  task automatic test_zero();
    clear_in();
    lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h55;
    step();
    lu_waddr = 5'd8; lu_wdata = 32'h88;
    #1;
    ncmp++; if (rf_we !== 1'b0) begin
      nfail++; $display("FAIL zero_lu_we got %b want 0", rf_we); end
    step();
    lu_valid = 1'b0;
    #1;
    ncmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8) begin
      nfail++; $display("FAIL zero_popped got we=%b a=%0d want we=1 a=8",
                        rf_we, rf_waddr); end
    step();
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = $urandom;
    #1;
    ncmp++; if (rf_we !== 1'b0) begin
      nfail++; $display("FAIL zero_pipe got %b want 0", rf_we); end
    step();
  endtask

  task automatic test_same_edge();
    clear_in();
    lu_issue = 1'b1; lu_dest = 5'd9;
    step();
    clear_in();
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    step();
    clear_in();
    lu_issue = 1'b1; lu_dest = 5'd9;
    #1;
    ncmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      nfail++; $display("FAIL same_commit got we=%b a=%0d want we=1 a=9",
                        rf_we, rf_waddr); end
    ncmp++; if (stall !== 1'b1) begin
      nfail++; $display("FAIL same_waw got %b want 1", stall); end
    step();
    clear_in();
    id_rs = 5'd9;
    #1;
    ncmp++; if (stall !== 1'b1) begin
      nfail++; $display("FAIL same_set_wins got %b want 0x1", stall); end
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h9A;
    step();
    lu_valid = 1'b0;
    step();
    #1;
    ncmp++; if (stall !== 1'b0) begin
      nfail++; $display("FAIL same_cleared got %b want 0", stall); end
    step();
  endtask

  task automatic test_reset_mid();
    clear_in();
    lu_issue = 1'b1; lu_dest = 5'd3;
    step();
    clear_in();
    pipe_we = 1'b1; pipe_waddr = 5'd21;
    lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'h1;
    step();
    lu_waddr = 5'd4; lu_wdata = 32'h2;
    step();
    lu_valid = 1'b0;
    #1;
    ncmp++; if (lu_ready !== 1'b0) begin
      nfail++; $display("FAIL mid_full got %b want 0", lu_ready); end
    pipe_we = 1'b0; id_rs = 5'd3;
    reset = 1'b0;
    #1;
    ncmp++; if (lu_ready !== 1'b1 || stall !== 1'b0) begin
      nfail++; $display("FAIL mid_reset got rdy=%b st=%b want 1 0",
                        lu_ready, stall); end
    ncmp++; if (rf_we !== 1'b0) begin
      nfail++; $display("FAIL mid_rf_we got %b want 0", rf_we); end
    step();
    reset = 1'b1;
    #1;
    ncmp++; if (rf_we !== 1'b0 || stall !== 1'b0) begin
      nfail++; $display("FAIL mid_after got we=%b st=%b want 0 0",
                        rf_we, stall); end
    step();
  endtask

  task automatic test_random();
    bit held = 1'b0;
    clear_in();
    for (int n = 0; n < 600; n++) begin
      pipe_we    = ($urandom_range(0, 9) < 6);
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      if (!held) begin
        lu_valid = ($urandom_range(0, 2) == 0);
        lu_waddr = 5'($urandom_range(0, 7));
        lu_wdata = $urandom;
      end
      lu_issue = ($urandom_range(0, 4) == 0);
      lu_dest  = 5'($urandom_range(0, 7));
      id_rs    = 5'($urandom_range(0, 7));
      id_rt    = 5'($urandom_range(0, 7));
      id_we    = $urandom_range(0, 1);
      id_dest  = 5'($urandom_range(0, 7));
      model_eval();
      #1;
      ncmp++; if (lu_ready !== e_ready) begin
        nfail++; $display("FAIL rnd_ready n=%0d got %b want %b",
                          n, lu_ready, e_ready); end
      ncmp++; if (stall !== e_stall) begin
        nfail++; $display("FAIL rnd_stall n=%0d got %b want %b",
                          n, stall, e_stall); end
      ncmp++; if (rf_we !== e_we) begin
        nfail++; $display("FAIL rnd_we n=%0d got %b want %b",
                          n, rf_we, e_we); end
      if (e_we) begin
        ncmp++; if (rf_waddr !== e_addr || rf_wdata !== e_data) begin
          nfail++; $display("FAIL rnd_write n=%0d got %0d:%h want %0d:%h",
                            n, rf_waddr, rf_wdata, e_addr, e_data); end
      end
      held = lu_valid && !e_ready;
      step();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    model_clear();
    test_reset();
    test_raw();
    test_starve();
    test_full();
    test_zero();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
